// File: rtl/apx_pkg.sv
// Shared definitions for the approximate adder pipeline: the arithmetic
// mode encodings and the width of the approximate-bit-count field.
package apx_pkg;

  // Arithmetic mode carried by each transaction. The reserved code
  // behaves like accurate mode everywhere it is decoded.
  typedef enum logic [1:0] {
    MODE_ACC   = 2'b00,
    MODE_TRUNC = 2'b01,
    MODE_ROUND = 2'b10,
    MODE_RSVD  = 2'b11
  } apx_mode_e;

  // Bits needed to hold an approximate-bit count in 0..nab_max.
  function automatic int nab_width(input int nab_max);
    return (nab_max < 1) ? 1 : $clog2(nab_max + 1);
  endfunction

endpackage

// File: rtl/apx_add_core.sv
// Combinational approximate adder: produces the approximate W+1-bit sum for
// the selected mode, the exact sum alongside it, and a flag when they differ.
module apx_add_core
  import apx_pkg::*;
#(
  parameter int W       = 32,
  parameter int NAB_MAX = 8
) (
  input  apx_mode_e                          mode,
  input  logic [nab_width(NAB_MAX)-1:0]      n,
  input  logic [W-1:0]                       a,
  input  logic [W-1:0]                       b,
  output logic [W-1:0]                       c,
  output logic                               cout,
  output logic [W-1:0]                       exact,
  output logic                               exact_cout,
  output logic                               err
);

  localparam int NW = nab_width(NAB_MAX);

  logic [W:0]    a_ext;
  logic [W:0]    b_ext;
  logic [W:0]    exact_s;
  logic [W:0]    trunc_s;
  logic [W:0]    round_s;
  logic [W:0]    approx_s;
  logic [W:0]    round_inc;
  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [NW-1:0] n_m1;
  logic          r;

  // Evaluate all three candidate sums and pick the one the mode asks for.
  always_comb begin
    a_ext   = {1'b0, a};
    b_ext   = {1'b0, b};
    exact_s = a_ext + b_ext;

    // Dropping the low n bits of each operand before adding is the whole
    // truncation scheme; the shift back restores the weight.
    trunc_s = ((a_ext >> n) + (b_ext >> n)) << n;

    // Rounding looks at the most significant discarded bit of either
    // operand. With n = 0 nothing is discarded, so no increment.
    n_m1 = n - NW'(1);
    a_sh = a >> n_m1;
    b_sh = b >> n_m1;
    r    = (n != '0) ? (a_sh[0] | b_sh[0]) : 1'b0;

    round_inc = {{W{1'b0}}, r} << n;
    round_s   = trunc_s + round_inc;

    case (mode)
      MODE_TRUNC: approx_s = trunc_s;
      MODE_ROUND: approx_s = round_s;
      default:    approx_s = exact_s;
    endcase

    c          = approx_s[W-1:0];
    cout       = approx_s[W];
    exact      = exact_s[W-1:0];
    exact_cout = exact_s[W];
    err        = (approx_s != exact_s);
  end

endmodule

// File: rtl/apx_adder_pipe.sv
// Pipelined approximate adder with a runtime mode/width register, a
// valid/ready stream interface that stalls as a whole, and running error
// statistics gathered at the output handshake.
module apx_adder_pipe
  import apx_pkg::*;
#(
  parameter int W       = 32,
  parameter int NAB_MAX = 8,
  parameter int STAGES  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [1:0]                    cfg_mode,
  input  logic [nab_width(NAB_MAX)-1:0] cfg_nab,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W-1:0]                  in_a,
  input  logic [W-1:0]                  in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [W-1:0]                  out_c,
  output logic                          out_cout,
  output logic [W-1:0]                  out_exact,
  output logic                          out_err,
  input  logic                          stat_clr,
  output logic [31:0]                   err_cnt,
  output logic [W+15:0]                 err_sum
);

  localparam int              NW        = nab_width(NAB_MAX);
  localparam logic [NW-1:0]   NAB_LIMIT = NW'(NAB_MAX);
  localparam int              LAST      = STAGES - 1;

  // Configuration register
  apx_mode_e     mode_q, mode_d;
  logic [NW-1:0] nab_q,  nab_d;

  // Pipeline stage registers, index 0 is the stage fed by the core
  logic [STAGES-1:0]        v_q,   v_d;
  logic [STAGES-1:0][W-1:0] c_q,   c_d;
  logic [STAGES-1:0]        co_q,  co_d;
  logic [STAGES-1:0][W-1:0] ex_q,  ex_d;
  logic [STAGES-1:0]        exc_q, exc_d;
  logic [STAGES-1:0]        err_q, err_d;

  // Statistics
  logic [31:0]   err_cnt_q, err_cnt_d;
  logic [W+15:0] err_sum_q, err_sum_d;

  // Core outputs
  logic [W-1:0] core_c;
  logic         core_cout;
  logic [W-1:0] core_exact;
  logic         core_exact_cout;
  logic         core_err;

  logic         advance;
  logic         out_hs;
  logic [W:0]   approx_w;
  logic [W:0]   exact_w;
  logic [W:0]   abs_diff;
  logic [32:0]  cnt_inc;
  logic [W+16:0] sum_inc;

  // The whole pipeline moves together; it only holds when a result is
  // waiting at the output and the consumer is not taking it.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // The core always sees the current register contents, so a config write
  // in the accepting cycle only reaches the following transaction.
  apx_add_core #(
    .W       (W),
    .NAB_MAX (NAB_MAX)
  ) u_core (
    .mode       (mode_q),
    .n          (nab_q),
    .a          (in_a),
    .b          (in_b),
    .c          (core_c),
    .cout       (core_cout),
    .exact      (core_exact),
    .exact_cout (core_exact_cout),
    .err        (core_err)
  );

  // Config next-state: load on write, clamping the bit count to NAB_MAX.
  always_comb begin
    mode_d = mode_q;
    nab_d  = nab_q;
    if (cfg_we) begin
      mode_d = apx_mode_e'(cfg_mode);
      nab_d  = (cfg_nab > NAB_LIMIT) ? NAB_LIMIT : cfg_nab;
    end
  end

  // Config register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_ACC;
      nab_q  <= '0;
    end else begin
      mode_q <= mode_d;
      nab_q  <= nab_d;
    end
  end

  // Pipeline next-state: shift every stage by one when advancing; an idle
  // input cycle becomes a bubble rather than holding the previous data.
  always_comb begin
    v_d   = v_q;
    c_d   = c_q;
    co_d  = co_q;
    ex_d  = ex_q;
    exc_d = exc_q;
    err_d = err_q;
    if (advance) begin
      v_d[0]   = in_valid;
      c_d[0]   = core_c;
      co_d[0]  = core_cout;
      ex_d[0]  = core_exact;
      exc_d[0] = core_exact_cout;
      err_d[0] = core_err;
      for (int i = 1; i < STAGES; i++) begin
        v_d[i]   = v_q[i-1];
        c_d[i]   = c_q[i-1];
        co_d[i]  = co_q[i-1];
        ex_d[i]  = ex_q[i-1];
        exc_d[i] = exc_q[i-1];
        err_d[i] = err_q[i-1];
      end
    end
  end

  // Pipeline registers; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      co_q  <= '0;
      ex_q  <= '0;
      exc_q <= '0;
      err_q <= '0;
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      co_q  <= co_d;
      ex_q  <= ex_d;
      exc_q <= exc_d;
      err_q <= err_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign out_c     = c_q[LAST];
  assign out_cout  = co_q[LAST];
  assign out_exact = ex_q[LAST];
  assign out_err   = err_q[LAST];

  // Statistics next-state: clear wins, otherwise accumulate erroneous
  // results as they leave, saturating both counters.
  always_comb begin
    out_hs   = out_valid & out_ready;
    approx_w = {out_cout, out_c};
    exact_w  = {exc_q[LAST], out_exact};
    abs_diff = (exact_w >= approx_w) ? (exact_w - approx_w) : (approx_w - exact_w);
    cnt_inc  = {1'b0, err_cnt_q} + 33'd1;
    sum_inc  = {1'b0, err_sum_q} + {16'b0, abs_diff};

    err_cnt_d = err_cnt_q;
    err_sum_d = err_sum_q;
    if (stat_clr) begin
      err_cnt_d = '0;
      err_sum_d = '0;
    end else if (out_hs && out_err) begin
      err_cnt_d = cnt_inc[32]  ? '1 : cnt_inc[31:0];
      err_sum_d = sum_inc[W+16] ? '1 : sum_inc[W+15:0];
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
      err_sum_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_sum_q <= err_sum_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign err_sum = err_sum_q;

endmodule

// File: tb/tb_apx_adder_pipe.sv
// Scoreboard bench for apx_adder_pipe: the driver pushes reference results
// at acceptance, a negedge monitor pops and compares at each output handshake.
module tb_apx_adder_pipe;

  localparam int W       = 32;
  localparam int NAB_MAX = 8;
  localparam int STAGES  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [1:0]    cfg_mode;
  logic [3:0]    cfg_nab;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a, in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_c;
  logic          out_cout;
  logic [W-1:0]  out_exact;
  logic          out_err;
  logic          stat_clr;
  logic [31:0]   err_cnt;
  logic [W+15:0] err_sum;

  apx_adder_pipe #(.W(W), .NAB_MAX(NAB_MAX), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_nab(cfg_nab),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c), .out_cout(out_cout),
    .out_exact(out_exact), .out_err(out_err), .stat_clr(stat_clr),
    .err_cnt(err_cnt), .err_sum(err_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     c;
    logic            cout;
    logic [31:0]     exact;
    logic            err;
    longint unsigned diff;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   npop  = 0;

  logic [1:0] model_mode = 2'b00;
  int         model_n    = 0;
  bit         rand_rdy   = 1'b0;
  bit         man_rdy    = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the mode rules.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] m, input int n);
    exp_t e;
    longint unsigned ua, ub, ex, ap, p, half;
    bit r;
    ua = a; ub = b;
    p  = 64'd1 << n;
    ex = ua + ub;
    r  = 1'b0;
    if (n > 0) begin
      half = p / 2;
      r = ((ua / half) % 2 == 1) || ((ub / half) % 2 == 1);
    end
    case (m)
      2'b01:   ap = (ua / p + ub / p) * p;
      2'b10:   ap = (ua / p + ub / p) * p + (r ? p : 0);
      default: ap = ex;
    endcase
    ap = ap % (64'd1 << 33);
    e.c     = ap[31:0];
    e.cout  = ap[32];
    e.exact = ex[31:0];
    e.err   = (ap != ex);
    e.diff  = (ex > ap) ? ex - ap : ap - ex;
    return e;
  endfunction

  // out_ready driver: manual value or random back-pressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : man_rdy;
    end
  end

  // Monitor: scoreboard pop, stall stability, statistics model.
  longint unsigned m_cnt = 0;
  longint unsigned m_sum = 0;
  bit              held  = 1'b0;
  logic [31:0]     h_c, h_ex;
  logic            h_co, h_err;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      m_cnt = 0;
      m_sum = 0;
      held  = 1'b0;
    end else begin
      chk("err_cnt", 64'(err_cnt), m_cnt);
      chk("err_sum", 64'(err_sum), m_sum);
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_c", 64'(out_c), 64'(h_c));
        chk("hold_exact", 64'(out_exact), 64'(h_ex));
        chk("hold_cout_err", 64'({out_cout, out_err}), 64'({h_co, h_err}));
      end
      held = 1'b0;
      if (out_valid && !out_ready) begin
        held = 1'b1;
        h_c = out_c; h_ex = out_exact; h_co = out_cout; h_err = out_err;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      if (stat_clr) begin
        m_cnt = 0;
        m_sum = 0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output got=%h want=none", out_c);
        end else begin
          e = q.pop_front();
          npop++;
          $display("txn %0d c=%h cout=%b exact=%h err=%b", npop, out_c, out_cout, out_exact, out_err);
          chk("c", 64'(out_c), 64'(e.c));
          chk("cout", 64'(out_cout), 64'(e.cout));
          chk("exact", 64'(out_exact), 64'(e.exact));
          chk("err", 64'(out_err), 64'(e.err));
          if (!stat_clr && e.err) begin
            m_cnt = m_cnt + 1;
            m_sum = m_sum + e.diff;
          end
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cfg(input logic [1:0] m, input logic [3:0] nb);
    cfg_we = 1'b1; cfg_mode = m; cfg_nab = nb;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_mode = m;
    model_n    = (nb > NAB_MAX) ? NAB_MAX : int'(nb);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input bit do_cfg, input logic [1:0] m, input logic [3:0] nb);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b;
    if (do_cfg) begin
      cfg_we = 1'b1; cfg_mode = m; cfg_nab = nb;
    end
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(a, b, model_mode, model_n));
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    if (do_cfg) begin
      model_mode = m;
      model_n    = (nb > NAB_MAX) ? NAB_MAX : int'(nb);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout got=0 want=1");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int base;
    bit got;
    rst = 1'b1; cfg_we = 1'b0; cfg_mode = 2'b00; cfg_nab = 4'd0;
    in_valid = 1'b0; in_a = '0; in_b = '0; stat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_c", 64'({out_cout, out_c}), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Accurate wrap to carry-out
    cfg(2'b00, 4'd0);
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2'b00, 4'd0);
    // Truncation and rounding with n = 4
    cfg(2'b01, 4'd4);
    send(32'h0000_001F, 32'h0000_0011, 1'b0, 2'b00, 4'd0);
    cfg(2'b10, 4'd4);
    send(32'h0000_001F, 32'h0000_0011, 1'b0, 2'b00, 4'd0);
    // Over-range n clamps to NAB_MAX
    cfg(2'b10, 4'd15);
    send(32'h0000_01FF, 32'h0000_0080, 1'b0, 2'b00, 4'd0);
    cfg(2'b01, 4'd15);
    send(32'h1234_56FF, 32'h0000_00FF, 1'b0, 2'b00, 4'd0);
    // Reserved mode acts as accurate
    cfg(2'b11, 4'd6);
    send(32'h0000_003F, 32'h0000_0021, 1'b0, 2'b00, 4'd0);
    drain();

    // Config write concurrent with acceptance
    cfg(2'b00, 4'd0);
    send(32'h0000_001F, 32'h0000_0011, 1'b1, 2'b01, 4'd4);
    send(32'h0000_001F, 32'h0000_0011, 1'b0, 2'b00, 4'd0);
    drain();

    // Back-to-back stream with a 3-cycle output stall
    base = npop;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send($urandom, $urandom, 1'b0, 2'b00, 4'd0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 man_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 man_rdy = 1'b1;
      end
    join
    drain();
    chk("stream_count", 64'(npop - base), 64'd10);

    // stat_clr coincident with an erroneous output
    man_rdy = 1'b0;
    @(posedge clk); #1;
    cfg(2'b01, 4'd4);
    send(32'h0000_001F, 32'h0000_0011, 1'b0, 2'b00, 4'd0);
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = out_valid;
    end
    chk("clr_out_valid", 64'(got), 64'd1);
    @(posedge clk); #1;
    stat_clr = 1'b1; man_rdy = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    @(negedge clk);
    chk("clr_err_cnt", 64'(err_cnt), 64'd0);
    chk("clr_err_sum", 64'(err_sum), 64'd0);
    @(posedge clk); #1;
    drain();

    // Randomised traffic with random back-pressure and config changes
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0)
        cfg(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      send($urandom, $urandom, 1'b0, 2'b00, 4'd0);
    end
    drain();
    rand_rdy = 1'b0;
    man_rdy  = 1'b1;
    @(posedge clk); #1;

    // Reset with two transactions in flight
    cfg(2'b01, 4'd4);
    send(32'h0000_001F, 32'h0000_0011, 1'b0, 2'b00, 4'd0);
    send(32'h0000_002F, 32'h0000_0013, 1'b0, 2'b00, 4'd0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
    chk("midrst_err_sum", 64'(err_sum), 64'd0);
    q.delete();
    model_mode = 2'b00;
    model_n    = 0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("midrst_out_data", 64'({out_err, out_cout, out_c}), 64'd0);
    chk("midrst_exact", 64'(out_exact), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    base = npop;
    // Config is back to accurate after reset
    send(32'h0000_001F, 32'h0000_0011, 1'b0, 2'b00, 4'd0);
    drain();
    chk("postrst_count", 64'(npop - base), 64'd1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apx_adder_pipe.md
APX_ADDER_PIPE -- requirements
Module: apx_adder_pipe

Interface
REQ-001 SHALL have parameter W, default 32: operand and result width.
REQ-002 SHALL have parameter NAB_MAX, default 8: maximum number of approximate low bits (less than W).
REQ-003 SHALL have parameter STAGES, default 2: pipeline depth (1 or more).
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port cfg_we, input, 1: load cfg_mode/cfg_nab into the config register.
REQ-007 SHALL have port cfg_mode, input, 2: 00 accurate, 01 truncation, 10 rounding, 11 reserved (treated as accurate).
REQ-008 SHALL have port cfg_nab, input, clog2(NAB_MAX+1): number of approximate bits n.
REQ-009 SHALL have port in_valid / in_ready, input / output, 1 each: operand handshake.
REQ-010 SHALL have port in_a, in_b, input, W each: operands.
REQ-011 SHALL have port out_valid / out_ready, output / input, 1 each: result handshake.
REQ-012 SHALL have ports out_c (output, W) and out_cout (output, 1): approximate sum and carry-out.
REQ-013 SHALL have ports out_exact (output, W) and out_err (output, 1): exact sum; high when {out_cout,out_c} differs from the exact W+1-bit sum.
REQ-014 SHALL have port stat_clr, input, 1: clear statistics.
REQ-015 SHALL have ports err_cnt (output, 32) and err_sum (output, W+16): error statistics.

Function
REQ-016 SHALL saturate a cfg_nab value above NAB_MAX to NAB_MAX on load.
REQ-017 SHALL snapshot mode and n into each transaction at acceptance; a config write in the same cycle affects only the next transaction.
REQ-018 SHALL compute accurate mode as {cout,c} = a+b.
REQ-019 SHALL compute truncation mode as {cout,c} = ((a>>n)+(b>>n))<<n, low n bits zero.
REQ-020 SHALL compute rounding mode as the truncation result plus (r<<n), where r = a[n-1] OR b[n-1] and r = 0 when n = 0.
REQ-021 SHALL wrap all sums modulo 2^(W+1) for {cout,c}.
REQ-022 SHALL accept a transaction when in_valid AND in_ready.
REQ-023 SHALL drive in_ready = NOT out_valid OR out_ready (whole-pipeline stall).
REQ-024 SHALL present the result STAGES cycles after acceptance when unstalled; sustained throughput is 1 per cycle.
REQ-025 SHALL hold out_* stable while out_valid is high and out_ready is low.
REQ-026 SHALL, on each output handshake with out_err = 1, increment err_cnt and add |exact - approx| (W+1-bit) to err_sum, both saturating at all-ones.
REQ-027 SHALL give stat_clr precedence: the statistics clear to 0 and a coincident handshake is not counted.
REQ-028 SHALL not let the statistics influence the datapath.

Reset
REQ-029 SHALL, while rst is high, force out_valid = 0, all pipeline valids = 0, mode = 00, n = 0, err_cnt = 0 and err_sum = 0.
REQ-030 SHALL drop in-flight transactions on reset mid-operation, and SHALL accept none until rst is released.
REQ-031 SHALL reset out_c, out_cout, out_exact and out_err to 0.

Structure
REQ-032 SHALL place the mode encodings, the MODE_* constants and the nab width function in shared package apx_pkg.
REQ-033 SHALL implement the arithmetic in one combinational sub-module apx_add_core (mode, n, a, b -> c, cout, exact, err), instanced once at pipeline stage 1.

Verification
REQ-034 SHALL cover: accurate mode, a=FFFFFFFF, b=00000001 -> c=00000000, cout=1, out_err=0.
REQ-035 SHALL cover: truncation mode, n=4, a=0000001F, b=00000011 -> c=00000020, exact=00000030, out_err=1, err_sum += 10h.
REQ-036 SHALL cover: rounding mode, n=4, same operands -> c=00000030, out_err=0; cfg_nab=15 with NAB_MAX=8 -> n=8.
REQ-037 SHALL cover: back-to-back stream of 10 transactions with out_ready low for 3 cycles mid-stream -> no loss or duplication, outputs held stable, in_ready low during the stall.
REQ-038 SHALL cover: config write concurrent with acceptance -> that transaction uses the old mode, the next uses the new one.
REQ-039 SHALL cover: rst asserted with 2 transactions in flight -> out_valid=0 immediately and statistics zero; stat_clr coincident with an erroneous output -> err_cnt=0.
